// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, totals helper and the RGB pixel type.
// Rev 1.0
`default_nettype none

package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vga_rgb_t;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (count, wrap, raw active-low sync, active region).
// Rev 1.0
`default_nettype none

module vga_axis_counter #(
  parameter int unsigned TOTAL      = 800,
  parameter int unsigned SYNC_START = 656,
  parameter int unsigned SYNC_END   = 752,
  parameter int unsigned ACTIVE     = 640,
  parameter int unsigned W          = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         sync_n,
  output logic         active
);

  localparam logic [W-1:0] C_LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] C_SYNC_START = W'(SYNC_START);
  localparam logic [W-1:0] C_SYNC_END   = W'(SYNC_END);
  localparam logic [W-1:0] C_ACTIVE     = W'(ACTIVE);
  localparam logic [W-1:0] C_ONE        = W'(1);

  // wrap is qualified by en so the vertical axis only wraps on the last line's last pixel
  assign wrap   = en && (count == C_LAST);
  assign sync_n = !((count >= C_SYNC_START) && (count < C_SYNC_END));
  assign active = (count < C_ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + C_ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_scan_timing.sv
// vga_scan_timing: raster counters plus one DAC-side register stage aligning colour, syncs and blank.
// Rev 1.0
`default_nettype none

module vga_scan_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_active,
  input  logic [7:0] i_r,
  input  logic [7:0] i_g,
  input  logic [7:0] i_b,
  output logic [7:0] o_vga_r,
  output logic [7:0] o_vga_g,
  output logic [7:0] o_vga_b,
  output logic       o_vga_hs,
  output logic       o_vga_vs,
  output logic       o_vga_blank_n,
  output logic       o_vga_sync_n,
  output logic       o_vga_clk,
  output logic       o_frame
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  logic     h_wrap, v_wrap;
  logic     h_sync_n, v_sync_n;
  logic     h_active, v_active;
  vga_rgb_t pix_in, pix_q;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_END   (H_ACTIVE + H_FP + H_SYNC),
    .ACTIVE     (H_ACTIVE),
    .W          (10)
  ) u_h_axis (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .en     (1'b1),
    .count  (o_x),
    .wrap   (h_wrap),
    .sync_n (h_sync_n),
    .active (h_active)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_END   (V_ACTIVE + V_FP + V_SYNC),
    .ACTIVE     (V_ACTIVE),
    .W          (10)
  ) u_v_axis (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .en     (h_wrap),
    .count  (o_y),
    .wrap   (v_wrap),
    .sync_n (v_sync_n),
    .active (v_active)
  );

  assign o_active = h_active & v_active;

  always_comb begin
    pix_in = '0;
    if (o_active) begin
      pix_in.r = i_r;
      pix_in.g = i_g;
      pix_in.b = i_b;
    end
  end

  // Single stage: everything the DAC sees lags o_x/o_y by exactly one clock
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pix_q         <= '0;
      o_vga_hs      <= 1'b1;
      o_vga_vs      <= 1'b1;
      o_vga_blank_n <= 1'b0;
      o_frame       <= 1'b0;
    end else begin
      pix_q         <= pix_in;
      o_vga_hs      <= h_sync_n;
      o_vga_vs      <= v_sync_n;
      o_vga_blank_n <= o_active;
      o_frame       <= v_wrap;
    end
  end

  assign o_vga_r      = pix_q.r;
  assign o_vga_g      = pix_q.g;
  assign o_vga_b      = pix_q.b;
  assign o_vga_sync_n = 1'b0;
  assign o_vga_clk    = i_clk;

endmodule

`default_nettype wire

// File: tb/tb_vga_scan_timing.sv
// tb_vga_scan_timing: small-geometry instance checked by scoreboard and vector table; default instance checked on hsync timing.
// Rev 1.0
`default_nettype none

module tb_vga_scan_timing;
  import vga_pkg::*;

  localparam int SHA = 16, SHF = 4, SHS = 6, SHB = 4, SHT = 30;
  localparam int SVA = 8,  SVF = 2, SVS = 2, SVB = 3, SVT = 15;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       frame;
  } obs_t;

  typedef struct {
    int         tx;
    int         ty;
    logic [7:0] r, g, b;
    logic [7:0] er, eg, eb;
    logic       eblank, ehs, evs;
  } vec_t;

  logic clk = 1'b0;
  initial forever #20 clk = ~clk;

  logic       rst_n_s, rst_n_d;
  logic [7:0] s_ir, s_ig, s_ib, d_ir, d_ig, d_ib;
  logic [9:0] s_x, s_y, d_x, d_y;
  logic       s_act, d_act;
  logic [7:0] s_r, s_g, s_b, d_r, d_g, d_b;
  logic       s_hs, s_vs, s_bl, s_sn, s_vclk, s_frame;
  logic       d_hs, d_vs, d_bl, d_sn, d_vclk, d_frame;

  vga_scan_timing #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) dut_s (
    .i_clk(clk), .i_rst_n(rst_n_s), .o_x(s_x), .o_y(s_y), .o_active(s_act),
    .i_r(s_ir), .i_g(s_ig), .i_b(s_ib), .o_vga_r(s_r), .o_vga_g(s_g), .o_vga_b(s_b),
    .o_vga_hs(s_hs), .o_vga_vs(s_vs), .o_vga_blank_n(s_bl), .o_vga_sync_n(s_sn),
    .o_vga_clk(s_vclk), .o_frame(s_frame)
  );

  vga_scan_timing dut_d (
    .i_clk(clk), .i_rst_n(rst_n_d), .o_x(d_x), .o_y(d_y), .o_active(d_act),
    .i_r(d_ir), .i_g(d_ig), .i_b(d_ib), .o_vga_r(d_r), .o_vga_g(d_g), .o_vga_b(d_b),
    .o_vga_hs(d_hs), .o_vga_vs(d_vs), .o_vga_blank_n(d_bl), .o_vga_sync_n(d_sn),
    .o_vga_clk(d_vclk), .o_frame(d_frame)
  );

  int compared = 0, mismatched = 0;
  int mh, mv, dh, d_edges, d_fall1, d_fall2, d_rise1;
  int since_frame, vs_low;
  bit s_run, d_run, prev_hs, track_mode;
  logic [7:0] cr, cg, cb;
  obs_t sb_q[$];
  vec_t vecs[14];
  localparam obs_t RST_OBS = '{x: 10'd0, y: 10'd0, act: 1'b1, r: 8'd0, g: 8'd0, b: 8'd0,
                               hs: 1'b1, vs: 1'b1, blank: 1'b0, frame: 1'b0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic obs_t predict(input int h, input int v, input logic [7:0] r,
                                   input logic [7:0] g, input logic [7:0] b);
    obs_t p;
    int nh, nv;
    logic vis;
    vis = (h < SHA) && (v < SVA);
    nh  = (h == SHT - 1) ? 0 : h + 1;
    nv  = v;
    if (h == SHT - 1) nv = (v == SVT - 1) ? 0 : v + 1;
    p.x     = 10'(nh);
    p.y     = 10'(nv);
    p.act   = (nh < SHA) && (nv < SVA);
    p.r     = vis ? r : 8'h00;
    p.g     = vis ? g : 8'h00;
    p.b     = vis ? b : 8'h00;
    p.hs    = !((h >= SHA + SHF) && (h < SHA + SHF + SHS));
    p.vs    = !((v >= SVA + SVF) && (v < SVA + SVF + SVS));
    p.blank = vis;
    p.frame = (h == SHT - 1) && (v == SVT - 1);
    return p;
  endfunction

  function automatic obs_t sample_s();
    return '{x: s_x, y: s_y, act: s_act, r: s_r, g: s_g, b: s_b,
             hs: s_hs, vs: s_vs, blank: s_bl, frame: s_frame};
  endfunction

  function automatic obs_t sample_d();
    return '{x: d_x, y: d_y, act: d_act, r: d_r, g: d_g, b: d_b,
             hs: d_hs, vs: d_vs, blank: d_bl, frame: d_frame};
  endfunction

  // One clock: drive inputs for the current model pixel, push the prediction, then compare after the edge
  task automatic tick();
    obs_t e;
    int pre_dh;
    if (track_mode) begin
      s_ir = 8'(mh);
      s_ig = ~8'(mh);
      s_ib = 8'(mv);
    end else begin
      s_ir = cr;
      s_ig = cg;
      s_ib = cb;
    end
    if (s_run) sb_q.push_back(predict(mh, mv, s_ir, s_ig, s_ib));
    pre_dh = dh;
    @(posedge clk);
    #1;
    if (s_run) begin
      e  = sb_q.pop_front();
      if (mh == SHT - 1) mv = (mv == SVT - 1) ? 0 : mv + 1;
      mh = (mh == SHT - 1) ? 0 : mh + 1;
      check("scan", 64'(sample_s()), 64'(e));
      since_frame++;
      if (!s_vs) vs_low++;
      if (s_frame) begin
        check("frame_period", 64'(since_frame), 64'(SHT * SVT));
        check("vs_low_clks", 64'(vs_low), 64'(SVS * SHT));
        since_frame = 0;
        vs_low      = 0;
      end
    end
    if (d_run) begin
      dh = (dh == 799) ? 0 : dh + 1;
      d_edges++;
      check("d_x", 64'(d_x), 64'(dh));
      if (pre_dh == 639) check("d_last_visible", {d_bl, d_r}, {1'b1, 8'hff});
      if (pre_dh == 640) check("d_first_blank", {d_bl, d_r}, {1'b0, 8'h00});
      if (prev_hs && !d_hs) begin
        if (d_fall1 < 0) d_fall1 = d_edges;
        else if (d_fall2 < 0) d_fall2 = d_edges;
      end
      if (!prev_hs && d_hs && d_rise1 < 0) d_rise1 = d_edges;
      prev_hs = d_hs;
    end
  endtask

  task automatic wait_pos(input int tx, input int ty);
    int n;
    n = 0;
    while (!(mh == tx && mv == ty) && n < 2 * SHT * SVT) begin
      tick();
      n++;
    end
    if (n >= 2 * SHT * SVT) timeout("wait_pos");
  endtask

  task automatic d_restart();
    dh      = 0;
    d_edges = 0;
    d_fall1 = -1;
    d_fall2 = -1;
    d_rise1 = -1;
    prev_hs = 1'b1;
  endtask

  initial begin
    int n;
    vecs[0]  = '{0,  0,  8'd11, 8'd22, 8'd33, 8'd11, 8'd22, 8'd33, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{15, 0,  8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{16, 0,  8'hff, 8'hff, 8'hff, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{19, 0,  8'hff, 8'hff, 8'hff, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{20, 0,  8'hff, 8'hff, 8'hff, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{25, 0,  8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{26, 0,  8'hff, 8'hff, 8'hff, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{15, 7,  8'ha5, 8'h5a, 8'hc3, 8'ha5, 8'h5a, 8'hc3, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{0,  8,  8'hff, 8'hff, 8'hff, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{5,  10, 8'hff, 8'hff, 8'hff, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{22, 11, 8'hff, 8'hff, 8'hff, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{0,  12, 8'hff, 8'hff, 8'hff, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{29, 14, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{0,  0,  8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03, 1'b1, 1'b1, 1'b1};

    rst_n_s = 1'b0; rst_n_d = 1'b0;
    d_ir = 8'hff; d_ig = 8'hff; d_ib = 8'hff;
    cr = 8'h00; cg = 8'h00; cb = 8'h00;
    track_mode = 1'b0; s_run = 1'b0; d_run = 1'b0;
    mh = 0; mv = 0; since_frame = 0; vs_low = 0;
    d_restart();
    repeat (3) tick();
    check("s_reset", 64'(sample_s()), 64'(RST_OBS));
    check("d_reset", 64'(sample_d()), 64'(RST_OBS));
    check("sync_n_tied", {s_sn, d_sn}, 2'b00);
    check("vga_clk", {s_vclk, d_vclk}, {clk, clk});

    rst_n_s = 1'b1; rst_n_d = 1'b1;
    s_run = 1'b1; d_run = 1'b1;

    // Vector table: fill colour between targets, exact inputs on the target pixel
    for (int i = 0; i < 14; i++) begin
      cr = 8'h77; cg = 8'h77; cb = 8'h77;
      wait_pos(vecs[i].tx, vecs[i].ty);
      cr = vecs[i].r; cg = vecs[i].g; cb = vecs[i].b;
      tick();
      check($sformatf("vec%0d", i), {s_r, s_g, s_b, s_bl, s_hs, s_vs},
            {vecs[i].er, vecs[i].eg, vecs[i].eb, vecs[i].eblank, vecs[i].ehs, vecs[i].evs});
    end

    track_mode = 1'b1;
    repeat (SHT * SVT) tick();
    track_mode = 1'b0;
    cr = 8'hff; cg = 8'hff; cb = 8'hff;
    repeat (SHT * SVT) tick();

    wait_pos(SHT - 1, SVT - 1);
    tick();
    check("wrap_xyf", {s_x, s_y, s_frame}, {10'd0, 10'd0, 1'b1});
    tick();
    check("wrap_after", {s_x, s_frame}, {10'd1, 1'b0});

    // Mid-frame reset while the delayed hsync is low
    wait_pos(22, 5);
    check("pre_reset_hs", {s_hs, s_x, s_y}, {1'b0, 10'd22, 10'd5});
    rst_n_s = 1'b0;
    #1;
    check("s_midreset", 64'(sample_s()), 64'(RST_OBS));
    s_run = 1'b0;
    repeat (2) tick();
    check("s_held", 64'(sample_s()), 64'(RST_OBS));
    rst_n_s = 1'b1;
    mh = 0; mv = 0; since_frame = 0; vs_low = 0;
    sb_q.delete();
    s_run = 1'b1;
    repeat (SHT * SVT + 5) tick();

    n = 0;
    while (d_fall2 < 0 && n < 3000) begin tick(); n++; end
    if (d_fall2 < 0) timeout("d_hs_fall2");
    check("d_hs_first_low", 64'(d_fall1), 64'd657);
    check("d_hs_width", 64'(d_rise1 - d_fall1), 64'd96);
    check("d_line_period", 64'(d_fall2 - d_fall1), 64'd800);

    n = 0;
    while (dh != 300 && n < 1000) begin tick(); n++; end
    if (dh != 300) timeout("d_reach_300");
    rst_n_d = 1'b0;
    #1;
    check("d_midreset", 64'(sample_d()), 64'(RST_OBS));
    d_run = 1'b0;
    repeat (2) tick();
    rst_n_d = 1'b1;
    d_restart();
    d_run = 1'b1;
    n = 0;
    while (d_rise1 < 0 && n < 1000) begin tick(); n++; end
    if (d_rise1 < 0) timeout("d_hs_rise_after_reset");
    check("d_hs_first_low_rst", 64'(d_fall1), 64'd657);
    check("d_hs_width_rst", 64'(d_rise1 - d_fall1), 64'd96);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
